linear_classifier_seq: RTL and testbench

Sequential, resource-shared version of the linear classifier. A single multiplier-accumulator is time-multiplexed across all (class, feature) products. A running argmax over the class scores is tracked, and the winning class and its score are reported with a start/busy/done handshake. It replaces the combinational classifier where area matters more than latency, and keeps the same bus packing for features and weights.

---
 rtl/linear_classifier_seq.sv | 135 +++++++++++++
 tb/tb_linear_classifier_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/linear_classifier_seq.sv
// Sequential linear classifier: one shared multiply-accumulate walks every
// (class, feature) product. A running argmax keeps the best class and its score,
// and the result is reported through a start/busy/done handshake.
module linear_classifier_seq #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned FEATURES = 2,
  parameter int unsigned C_WIDTH  = 2,
  localparam int unsigned NUM_CLASSES = 2 ** C_WIDTH,
  localparam int unsigned ACC_W       = 2 * WIDTH + $clog2(FEATURES)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [FEATURES*WIDTH-1:0]             features,
  input  logic [NUM_CLASSES*FEATURES*WIDTH-1:0] weights,
  output logic                                  busy,
  output logic                                  done,
  output logic [ACC_W-1:0]                      r_value,
  output logic [C_WIDTH-1:0]                    r_class
);

  // The feature counter needs at least one bit, even when FEATURES == 1.
  localparam int unsigned FW = (FEATURES > 1) ? $clog2(FEATURES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state, w_state_d;

  // Captured operands; the packed layout matches the input bus packing.
  logic [FEATURES-1:0][WIDTH-1:0]                  r_feat;
  logic [NUM_CLASSES-1:0][FEATURES-1:0][WIDTH-1:0] r_w;

  logic [FW-1:0]      r_f;
  logic [C_WIDTH-1:0] r_c;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_max_val;
  logic [C_WIDTH-1:0] r_max_cls;

  logic               w_busy_d, w_done_d;
  logic               w_last_f, w_last_c;
  logic [WIDTH-1:0]   w_fsel, w_wsel;
  logic [2*WIDTH-1:0] w_prod;
  logic [ACC_W-1:0]   w_sum;

  assign w_last_f = (r_f == FW'(FEATURES - 1));
  assign w_last_c = (r_c == {C_WIDTH{1'b1}});
  assign w_fsel   = r_feat[r_f];
  assign w_wsel   = r_w[r_c][r_f];
  assign w_prod   = {{WIDTH{1'b0}}, w_fsel} * {{WIDTH{1'b0}}, w_wsel};
  assign w_sum    = r_acc + ACC_W'(w_prod);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Next-state logic: a run walks every product, then spends one cycle in DONE.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (w_last_f && w_last_c) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Next values of the registered handshake outputs.
  always_comb begin
    w_busy_d = busy;
    w_done_d = 1'b0;
    unique case (r_state)
      StIdle:  if (start) w_busy_d = 1'b1;
      StRun:   w_busy_d = 1'b1;
      StDone:  begin
        w_busy_d = 1'b0;
        w_done_d = 1'b1;
      end
      default: w_busy_d = 1'b0;
    endcase
  end

  // Datapath: operand capture, MAC, running argmax and the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      r_value   <= '0;
      r_class   <= '0;
      r_feat    <= '0;
      r_w       <= '0;
      r_f       <= '0;
      r_c       <= '0;
      r_acc     <= '0;
      r_max_val <= '0;
      r_max_cls <= '0;
    end else begin
      busy <= w_busy_d;
      done <= w_done_d;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_feat <= features;
            r_w    <= weights;
            r_f    <= '0;
            r_c    <= '0;
            r_acc  <= '0;
          end
        end
        StRun: begin
          if (!w_last_f) begin
            r_acc <= w_sum;
            r_f   <= r_f + FW'(1);
          end else begin
            // Strict compare so ties keep the lowest class index.
            if ((r_c == '0) || (w_sum > r_max_val)) begin
              r_max_val <= w_sum;
              r_max_cls <= r_c;
            end
            r_acc <= '0;
            r_f   <= '0;
            if (!w_last_c) r_c <= r_c + C_WIDTH'(1);
          end
        end
        StDone: begin
          r_value <= r_max_val;
          r_class <= r_max_cls;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_classifier_seq.sv
// Self-checking bench for linear_classifier_seq: directed and random vectors
// compared against a plain-arithmetic argmax model.
module tb_linear_classifier_seq;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned FEATURES = 2;
  localparam int unsigned C_WIDTH  = 2;
  localparam int unsigned NC       = 2 ** C_WIDTH;
  localparam int unsigned ACC_W    = 2 * WIDTH + $clog2(FEATURES);
  localparam int unsigned PRODS    = NC * FEATURES;

  logic                           clk;
  logic                           rst_n;
  logic                           start;
  logic [FEATURES*WIDTH-1:0]      features;
  logic [NC*FEATURES*WIDTH-1:0]   weights;
  logic                           busy;
  logic                           done;
  logic [ACC_W-1:0]               r_value;
  logic [C_WIDTH-1:0]             r_class;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] tv_feat [FEATURES];
  logic [WIDTH-1:0] tv_w    [NC][FEATURES];

  linear_classifier_seq #(
    .WIDTH    (WIDTH),
    .FEATURES (FEATURES),
    .C_WIDTH  (C_WIDTH)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .features (features),
    .weights  (weights),
    .busy     (busy),
    .done     (done),
    .r_value  (r_value),
    .r_class  (r_class)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", tag, obs, obs, exp);
    end
  endtask

  // Reference: score every class, pick the first maximum.
  function automatic void model(output int unsigned exp_val, output int unsigned exp_cls);
    int unsigned sums [NC];
    for (int c = 0; c < NC; c++) begin
      sums[c] = 0;
      for (int f = 0; f < FEATURES; f++) begin
        int unsigned a, b;
        a = tv_feat[f];
        b = tv_w[c][f];
        sums[c] += a * b;
      end
    end
    exp_cls = 0;
    exp_val = sums[0];
    for (int c = 1; c < NC; c++) begin
      if (sums[c] > exp_val) begin
        exp_val = sums[c];
        exp_cls = c;
      end
    end
  endfunction

  task automatic drive_vec();
    for (int f = 0; f < FEATURES; f++) features[f*WIDTH +: WIDTH] = tv_feat[f];
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < FEATURES; f++)
        weights[(c*FEATURES+f)*WIDTH +: WIDTH] = tv_w[c][f];
  endtask

  task automatic set_vec(input int f0, input int f1, input int w00, input int w01,
                         input int w10, input int w11, input int w20, input int w21,
                         input int w30, input int w31);
    tv_feat[0] = f0[WIDTH-1:0];  tv_feat[1] = f1[WIDTH-1:0];
    tv_w[0][0] = w00[WIDTH-1:0]; tv_w[0][1] = w01[WIDTH-1:0];
    tv_w[1][0] = w10[WIDTH-1:0]; tv_w[1][1] = w11[WIDTH-1:0];
    tv_w[2][0] = w20[WIDTH-1:0]; tv_w[2][1] = w21[WIDTH-1:0];
    tv_w[3][0] = w30[WIDTH-1:0]; tv_w[3][1] = w31[WIDTH-1:0];
  endtask

  task automatic rand_vec();
    for (int f = 0; f < FEATURES; f++) tv_feat[f] = WIDTH'($urandom_range(0, 255));
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < FEATURES; f++) tv_w[c][f] = WIDTH'($urandom_range(0, 255));
  endtask

  // One classification. skip_wait: already at a falling edge; hold: leave start high;
  // mutate: scramble input buses during RUN; poke_at: cycle to pulse start while busy.
  task automatic run_vec(input string tag, input bit skip_wait, input bit hold,
                         input bit mutate, input int poke_at);
    int unsigned ev, ec;
    int cycles, busy_cnt;
    bit seen;
    if (!skip_wait) @(negedge clk);
    drive_vec();
    start = 1'b1;
    model(ev, ec);
    @(posedge clk);
    cycles = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (cycles < 40 && !seen) begin
      @(negedge clk);
      cycles++;
      if (cycles == poke_at)  start = 1'b1;
      else if (!hold)         start = 1'b0;
      if (mutate) begin
        features = FEATURES*WIDTH'($urandom);
        weights  = {$urandom, $urandom};
      end
      if (done)      seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_latency"},   32'(cycles), 32'(PRODS + 2));
    check_eq({tag, "_busy_cyc"},  32'(busy_cnt), 32'(PRODS + 1));
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_eq({tag, "_value"}, 32'(r_value), ev);
    check_eq({tag, "_class"}, 32'(r_class), ec);
    if (!hold) begin
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
      check_eq({tag, "_value_hold"}, 32'(r_value), ev);
    end
  endtask

  initial begin
    int dcnt, bcnt;
    rst_n = 1'b1;
    start = 1'b0;
    features = '0;
    weights = '0;

    // Asynchronous reset before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_value", 32'(r_value), 32'd0);
    check_eq("rst_class", 32'(r_class), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: nothing happens.
    dcnt = 0; bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check_eq("idle_done", 32'(dcnt), 32'd0);
    check_eq("idle_busy", 32'(bcnt), 32'd0);

    set_vec(10, 5, 1, 2, 3, 4, 2, 1, 1, 1);
    run_vec("basic", 1'b0, 1'b0, 1'b0, 0);
    check_eq("basic_exact_value", 32'(r_value), 32'd50);
    check_eq("basic_exact_class", 32'(r_class), 32'd1);

    // Back-to-back with start held high.
    set_vec(10, 5, 1, 2, 3, 4, 2, 1, 1, 1);
    run_vec("b2b_a", 1'b0, 1'b1, 1'b0, 0);
    set_vec(8, 12, 5, 2, 1, 1, 2, 3, 0, 5);
    run_vec("b2b_b", 1'b1, 1'b0, 1'b0, 0);
    check_eq("b2b_exact_value", 32'(r_value), 32'd64);
    check_eq("b2b_exact_class", 32'(r_class), 32'd0);

    set_vec(5, 5, 2, 4, 3, 3, 4, 2, 3, 3);
    run_vec("tie_all", 1'b0, 1'b0, 1'b0, 0);
    check_eq("tie_all_class", 32'(r_class), 32'd0);
    set_vec(5, 5, 0, 0, 3, 3, 4, 2, 3, 3);
    run_vec("tie_c0zero", 1'b0, 1'b0, 1'b0, 0);
    check_eq("tie_c0zero_class", 32'(r_class), 32'd1);

    set_vec(255, 255, 255, 255, 255, 255, 255, 255, 255, 255);
    run_vec("max_ops", 1'b0, 1'b0, 1'b1, 0);
    check_eq("max_ops_exact", 32'(r_value), 32'd130050);

    // Start pulsed mid-run must be ignored: one done, then silence.
    set_vec(8, 12, 5, 2, 1, 1, 2, 3, 0, 5);
    run_vec("poke", 1'b0, 1'b0, 1'b0, 3);
    dcnt = 0; bcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check_eq("poke_extra_done", 32'(dcnt), 32'd0);
    check_eq("poke_extra_busy", 32'(bcnt), 32'd0);

    // Reset in the middle of a run.
    set_vec(10, 5, 1, 2, 3, 4, 2, 1, 1, 1);
    @(negedge clk);
    drive_vec();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy",  32'(busy), 32'd0);
    check_eq("midrst_done",  32'(done), 32'd0);
    check_eq("midrst_value", 32'(r_value), 32'd0);
    check_eq("midrst_class", 32'(r_class), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check_eq("midrst_no_done", 32'(dcnt), 32'd0);
    run_vec("after_rst", 1'b0, 1'b0, 1'b0, 0);

    // Random vectors.
    for (int i = 0; i < 20; i++) begin
      rand_vec();
      run_vec($sformatf("rand%0d", i), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
